timer_dev: RTL and testbench
============================

TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 addr  input  2  word select, from CPU byte address bits [3:2]: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-004 be  input  4  byte enables for writes; be[i] qualifies wdata[8i+7:8i].
REQ-005 wdata  input  32  CPU store data.
REQ-006 we  input  1  store strobe, one cycle per access.
REQ-007 rdata  output  32  load data, combinational from addr.
REQ-008 irq  output  1  interrupt request, level.

Function
REQ-009 Registers: CTRL[3:0] = {IM, MODE[1:0], EN}, upper bits read 0; PRESET[31:0]; COUNT[31:0] read-only.
REQ-010 Write: on rising edge with we=1, the bytes of CTRL/PRESET selected by be take wdata; writes to COUNT or addr 3 are ignored.
REQ-011 Read: rdata = CTRL (zero-extended), PRESET, COUNT or 0 for addr 0/1/2/3; no wait states, zero latency.
REQ-012 FSM states IDLE, LOAD, CNT, INT; reset state IDLE.
REQ-013 IDLE: EN=1 -> LOAD; else stay; COUNT holds.
REQ-014 LOAD: COUNT <= PRESET; -> CNT.
REQ-015 CNT: EN=0 -> IDLE, COUNT holds; else COUNT=0 -> INT; else COUNT <= COUNT-1.
REQ-016 Entering INT sets irq_pending.
REQ-017 INT, MODE=0 (one-shot): EN <= 0, -> IDLE; irq_pending stays set until any CTRL write.
REQ-018 INT, MODE=1 (auto-reload): -> LOAD; irq_pending clears on leaving INT (one-cycle pulse).
REQ-019 MODE=2/3 behave as MODE=0.
REQ-020 irq = irq_pending & IM.
REQ-021 PRESET write during CNT has no effect on COUNT until the next LOAD.
REQ-022 CPU CTRL write in the same cycle as INT's EN clear: CPU write wins; it also clears irq_pending.
REQ-023 PRESET=0: LOAD -> CNT(COUNT=0) -> INT; no wrap to 0xFFFFFFFF, COUNT never decrements below 0.
REQ-024 Latency: EN written at edge E0 with PRESET=N, MODE=0 -> irq_pending set at edge E0+N+3.

Reset
REQ-025 reset low: state IDLE, CTRL=0, PRESET=0, COUNT=0, irq_pending=0 immediately, independent of clk.
REQ-026 reset mid-count aborts the count; no irq after release until a new EN write.
REQ-027 rdata reflects reset register values (0) while reset is low.

Configuration
REQ-028 Macro TIMER_AUTORELOAD_EN defined: MODE=1 behaves per REQ-018.
REQ-029 Macro TIMER_AUTORELOAD_EN undefined: MODE bits still writable/readable, all modes behave as MODE=0; no reload path synthesized.

Verification
REQ-030 PRESET=3, CTRL=0x9 (EN, IM, MODE0) -> irq rises at 6th edge after write, EN reads 0, COUNT reads 0, irq holds until CTRL write of 0x0 clears it.
REQ-031 PRESET=2, CTRL=0xB (MODE1) with TIMER_AUTORELOAD_EN -> one-cycle irq pulses every 5 cycles; without macro -> single held irq.
REQ-032 be=4'b0011, wdata=0xAABBCCDD to PRESET=0x11223344 -> PRESET reads 0x1122CCDD.
REQ-033 Counting with COUNT=5, write CTRL=0x8 (EN=0) -> COUNT freezes at value 1 cycle after write; no irq.
REQ-034 reset low during CNT with COUNT=10 -> all registers 0, irq 0 immediately; after release, no irq for 20 cycles.
REQ-035 PRESET=0, CTRL=0x9 -> irq at 3rd edge after write; write to COUNT (addr 2) -> readback unchanged.

Source files
------------

// File: rtl/timer_dev.sv
`timescale 1ns/1ps
// timer_dev -- memory-mapped down-counting timer with a level interrupt.
//
// Register map (word address = CPU byte address bits [3:2]):
//   0 CTRL   [3:0] = {IM, MODE[1:0], EN}, upper bits read 0
//   1 PRESET [31:0] reload value
//   2 COUNT  [31:0] current count, read-only (writes ignored)
//   3 reserved, reads 0, writes ignored
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   addr   word select
//   be     byte enables for writes (be[i] qualifies wdata[8i+7:8i])
//   wdata  store data
//   we     store strobe, one cycle per access
//   rdata  load data, combinational from addr
//   irq    interrupt request = irq_pending & IM
//
// Optional feature: define TIMER_AUTORELOAD_EN to make MODE=1 reload
// PRESET after each expiry (one-cycle irq pulse per period). Without it
// every MODE is one-shot and no reload path exists.
//
// Handshake: there is none beyond we; a store completes on the edge where
// we=1, a load is valid in the same cycle addr is presented.
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic [31:0] count_nxt;
  logic        irq_pending;
  logic        ctrl_wr;
  logic        preset_wr;
  logic        reload;
  logic        clear_en;
  logic        set_pend;
  logic        clr_pend_fsm;

  assign ctrl_wr   = we && (addr == 2'd0);
  assign preset_wr = we && (addr == 2'd1);

`ifdef TIMER_AUTORELOAD_EN
  assign reload = (ctrl[2:1] == 2'd1);
`else
  assign reload = 1'b0;
`endif

  // Next-state / count logic. COUNT only moves in LOAD and in CNT while
  // nonzero, so it can never wrap below zero.
  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    clear_en     = 1'b0;
    set_pend     = 1'b0;
    clr_pend_fsm = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl[0]) state_nxt = LOAD;
      end
      LOAD: begin
        count_nxt = preset;
        state_nxt = CNT;
      end
      CNT: begin
        if (!ctrl[0]) begin
          state_nxt = IDLE;
        end else if (count == 32'd0) begin
          state_nxt = INT;
          set_pend  = 1'b1;
        end else begin
          count_nxt = count - 32'd1;
        end
      end
      INT: begin
        if (reload) begin
          state_nxt    = LOAD;
          clr_pend_fsm = 1'b1;
        end else begin
          state_nxt = IDLE;
          clear_en  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= 32'd0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // A CPU write to the CTRL byte takes priority over the one-shot EN clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl <= 4'd0;
    end else if (ctrl_wr && be[0]) begin
      ctrl <= wdata[3:0];
    end else if (clear_en) begin
      ctrl[0] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      preset <= 32'd0;
    end else if (preset_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) preset[8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // A fresh expiry outranks a clear arriving on the same edge so that no
  // expiry event is ever lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_pending <= 1'b0;
    end else if (set_pend) begin
      irq_pending <= 1'b1;
    end else if (ctrl_wr || clr_pend_fsm) begin
      irq_pending <= 1'b0;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      2'd0:    rdata = {28'd0, ctrl};
      2'd1:    rdata = preset;
      2'd2:    rdata = count;
      default: rdata = 32'd0;
    endcase
  end

  assign irq = irq_pending & ctrl[3];

endmodule

// File: tb/tb_timer_dev.sv
`timescale 1ns/1ps
// tb_timer_dev -- self-checking bench for timer_dev.
// Driver tasks queue an expected {irq, rdata} with each read request; a
// negedge monitor pops and compares. Timing expectations come from an
// arithmetic model of the count/expiry schedule.
module tb_timer_dev;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [3:0]  be = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic        we = 1'b0;
  logic [31:0] rdata;
  logic        irq;

  timer_dev dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .be    (be),
    .wdata (wdata),
    .we    (we),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

`ifdef TIMER_AUTORELOAD_EN
  localparam bit AUTORELOAD = 1'b1;
`else
  localparam bit AUTORELOAD = 1'b0;
`endif

  localparam logic [1:0] A_CTRL = 2'd0, A_PRESET = 2'd1, A_COUNT = 2'd2, A_RSV = 2'd3;

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        chk_valid = 1'b0;
  logic [32:0] mon_exp;
  string       mon_name;

  always @(negedge clk) begin
    if (chk_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL monitor_underflow: got irq=%0b rdata=0x%08h, no expected entry", irq, rdata);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if ({irq, rdata} !== mon_exp) begin
          errors++;
          $display("FAIL %s @%0t: got irq=%0b rdata=0x%08h expected irq=%0b rdata=0x%08h",
                   mon_name, $time, irq, rdata, mon_exp[32], mon_exp[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    chk_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [3:0] b, input logic [31:0] d);
    addr  = a;
    be    = b;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
    be    = 4'd0;
  endtask

  task automatic chk_rd(input logic [1:0] a, input logic [31:0] d, input logic i, input string nm);
    addr = a;
    exp_q.push_back({i, d});
    name_q.push_back(nm);
    chk_valid = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // ---------------- reference model ----------------
  // k = edges since the CTRL write that set EN (k=0 right after it).
  // Schedule: 2 edges to reach counting with COUNT=n, n decrements, then
  // expiry at k=n+3. Reload mode repeats with period n+3. COUNT is 0
  // before the first load because every model run starts from reset.
  function automatic logic [31:0] mdl_count(input int n, input int k, input bit rl);
    int p;
    if (!rl) begin
      if (k <= 1) return 32'd0;
      if (k <= n + 2) return 32'(n - (k - 2));
      return 32'd0;
    end
    if (k == 0) return 32'd0;
    p = (k - 1) % (n + 3);
    if (p == 0) return 32'd0;
    if (p <= n + 1) return 32'(n - (p - 1));
    return 32'd0;
  endfunction

  function automatic logic mdl_pend(input int n, input int k, input bit rl);
    if (!rl) return (k >= n + 3);
    if (k == 0) return 1'b0;
    return ((k - 1) % (n + 3)) == (n + 2);
  endfunction

  task automatic run_case(input int n, input logic im, input logic [1:0] mode);
    bit rl;
    int kmax;
    rl   = AUTORELOAD && (mode == 2'd1);
    kmax = 3 * (n + 3) + 1;
    do_reset();
    cpu_write(A_PRESET, 4'hF, 32'(n));
    cpu_write(A_CTRL, 4'hF, {28'd0, im, mode, 1'b1});
    for (int k = 0; k <= kmax; k++)
      chk_rd(A_COUNT, mdl_count(n, k, rl), im & mdl_pend(n, k, rl), "model_count_irq");
    chk_rd(A_CTRL, {28'd0, im, mode, rl}, im & mdl_pend(n, kmax + 1, rl), "model_ctrl_en");
    if (!rl) begin
      cpu_write(A_CTRL, 4'hF, 32'd0);
      chk_rd(A_CTRL, 32'd0, 1'b0, "model_irq_clear");
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] c030 [8];
    logic        i030 [8];
    c030 = '{32'd0, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0};
    i030 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    tick();
    // Reset values visible while reset is held low.
    chk_rd(A_CTRL,   32'd0, 1'b0, "rst_ctrl");
    chk_rd(A_PRESET, 32'd0, 1'b0, "rst_preset");
    chk_rd(A_COUNT,  32'd0, 1'b0, "rst_count");
    chk_rd(A_RSV,    32'd0, 1'b0, "rst_rsv");
    reset = 1'b1;

    // Byte-enable merge.
    cpu_write(A_PRESET, 4'hF, 32'h11223344);
    cpu_write(A_PRESET, 4'b0011, 32'hAABBCCDD);
    chk_rd(A_PRESET, 32'h1122CCDD, 1'b0, "be_merge");
    // COUNT and reserved word ignore writes; CTRL upper bits read 0.
    cpu_write(A_COUNT, 4'hF, 32'h0000FFFF);
    chk_rd(A_COUNT, 32'd0, 1'b0, "count_ro");
    cpu_write(A_RSV, 4'hF, 32'hDEADBEEF);
    chk_rd(A_RSV, 32'd0, 1'b0, "rsv_read");
    chk_rd(A_PRESET, 32'h1122CCDD, 1'b0, "rsv_no_alias");
    cpu_write(A_CTRL, 4'hF, 32'hFFFFFFF0);
    chk_rd(A_CTRL, 32'd0, 1'b0, "ctrl_upper_zero");

    // One-shot, PRESET=3: irq at the 6th edge, EN auto-clears, CTRL write clears irq.
    cpu_write(A_PRESET, 4'hF, 32'd3);
    cpu_write(A_CTRL, 4'hF, 32'h9);
    for (int k = 0; k < 8; k++) chk_rd(A_COUNT, c030[k], i030[k], "oneshot3");
    chk_rd(A_CTRL, 32'h8, 1'b1, "oneshot3_en_clr");
    cpu_write(A_CTRL, 4'hF, 32'h0);
    chk_rd(A_CTRL, 32'h0, 1'b0, "oneshot3_irq_clr");

    // Stop mid-count at COUNT=5: one more decrement lands, then it freezes.
    cpu_write(A_PRESET, 4'hF, 32'd10);
    cpu_write(A_CTRL, 4'hF, 32'h9);
    idle(7);
    cpu_write(A_CTRL, 4'hF, 32'h8);
    for (int k = 0; k < 5; k++) chk_rd(A_COUNT, 32'd4, 1'b0, "freeze");
    chk_rd(A_CTRL, 32'h8, 1'b0, "freeze_ctrl");

    // Asynchronous reset mid-count, then silence.
    cpu_write(A_CTRL, 4'hF, 32'h9);
    idle(2);
    reset = 1'b0;
    chk_rd(A_COUNT,  32'd0, 1'b0, "async_rst_count");
    chk_rd(A_CTRL,   32'd0, 1'b0, "async_rst_ctrl");
    chk_rd(A_PRESET, 32'd0, 1'b0, "async_rst_preset");
    reset = 1'b1;
    for (int k = 0; k < 20; k++) chk_rd(A_COUNT, 32'd0, 1'b0, "post_rst_quiet");

    // PRESET=0: irq on the 3rd edge; COUNT write ignored.
    cpu_write(A_PRESET, 4'hF, 32'd0);
    cpu_write(A_CTRL, 4'hF, 32'h9);
    chk_rd(A_COUNT, 32'd0, 1'b0, "preset0");
    chk_rd(A_COUNT, 32'd0, 1'b0, "preset0");
    chk_rd(A_COUNT, 32'd0, 1'b0, "preset0");
    chk_rd(A_COUNT, 32'd0, 1'b1, "preset0_irq");
    cpu_write(A_COUNT, 4'hF, 32'h1234);
    chk_rd(A_COUNT, 32'd0, 1'b1, "preset0_count_ro");
    chk_rd(A_CTRL, 32'h8, 1'b1, "preset0_en_clr");
    cpu_write(A_CTRL, 4'hF, 32'h0);

    // CTRL write on the same edge as the one-shot EN clear: CPU wins.
    cpu_write(A_CTRL, 4'hF, 32'h9);
    idle(3);
    cpu_write(A_CTRL, 4'hF, 32'h9);
    chk_rd(A_CTRL,  32'h9, 1'b0, "wr_vs_int");
    chk_rd(A_COUNT, 32'd0, 1'b0, "wr_vs_int_restart");
    chk_rd(A_COUNT, 32'd0, 1'b0, "wr_vs_int_restart");
    chk_rd(A_COUNT, 32'd0, 1'b1, "wr_vs_int_refire");

    // Model-driven runs: fixed corner cases, then random.
    run_case(3, 1'b1, 2'd0);
    run_case(2, 1'b1, 2'd1);
    run_case(0, 1'b1, 2'd1);
    for (int r = 0; r < 10; r++)
      run_case(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));

    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
